move_cmd_gen: RTL
=================

// Module: move_cmd_gen
// PURPOSE
//  Produces the per-clock move commands (leftSignal/rightSignal/upSignal/downSignal) that the falling-piece core consumes.
//  Inputs are raw push-buttons, which the block synchronises and debounces. Left, right and down auto-repeat; up (rotate) does not.
//  A gravity timer injects periodic down requests. Output is at most one single-cycle pulse per clock, so the core never sees a held level.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000    cycles a synchronised button must stay stable before its debounced state changes (10 ms @ 50 MHz)
//  REPEAT_DELAY     15000000  cycles from the first pulse to the first auto-repeat pulse while the button is held
//  REPEAT_RATE      5000000   cycles between subsequent auto-repeat pulses
//  GRAVITY_PERIOD   25000000  cycles between gravity down requests (2 Hz @ 50 MHz)
//  CNT_W            26        width of every internal counter; must hold the largest parameter value
// PORTS
//  clk          in   1  system clock; all state is on posedge
//  reset        in   1  asynchronous, active-high reset
//  btn_left     in   1  raw button, active high, asynchronous to clk
//  btn_right    in   1  raw button, active high
//  btn_up       in   1  raw button (rotate), active high
//  btn_down     in   1  raw button (soft drop), active high
//  gravity_en   in   1  1 = gravity timer runs; 0 = timer holds at 0 and makes no requests
//  freeze       in   1  1 = suppress all output pulses (line clear/game over); pending requests are discarded
//  leftSignal   out  1  one-cycle pulse: shift piece one column left
//  rightSignal  out  1  one-cycle pulse: shift piece one column right
//  upSignal     out  1  one-cycle pulse: rotate piece
//  downSignal   out  1  one-cycle pulse: drop piece one row
// BEHAVIOUR
//  Reset (async): all outputs 0; sync flops, debounced states, counters and pending bits 0; every button FSM is IDLE.
//  Input path: 2-flop synchroniser per button, then a debounce counter.
//   - Debounce counter clears whenever the synced value equals the debounced value.
//   - When the counter reaches DEBOUNCE_CYCLES-1 with the values still differing, the debounced value takes the synced value.
//  Per-button FSM (left/right/down). Evaluated on the debounced level.
//   - IDLE  : rising edge of debounced -> raise request, go DELAY, counter=0
//   - DELAY : released -> IDLE; counter==REPEAT_DELAY-1 -> raise request, go REPEAT, counter=0
//   - REPEAT: released -> IDLE; counter==REPEAT_RATE-1 -> raise request, counter=0
//  Up FSM: IDLE/HELD only. A rising edge raises one request; no repeat until release and re-press.
//  Gravity: counter increments while gravity_en=1 and freeze=0. At GRAVITY_PERIOD-1 it wraps to 0 and raises a down request.
//  Pending set: one sticky bit per direction, set by a request and cleared when that pulse is issued.
//   - A second request for a direction that is already pending merges into it (gravity + soft drop in one cycle = one down pulse).
//  Arbiter: each cycle, if freeze=0, issue exactly one pending bit as a registered pulse. Fixed priority up > left > right > down.
//   - Latency: a request raised in cycle N pulses in cycle N+1 when it has top priority; a lower-priority request waits for free cycles.
//  Left+right simultaneously pending: left issues first, right next cycle (net zero move, both visible).
//  freeze=1: outputs forced 0 and pending bits cleared every cycle. FSMs and debouncers keep tracking buttons.
//   - A button held through freeze does not re-fire on freeze release, only at its next repeat boundary.
//  Reset mid-operation: immediate return to reset state; any pulse in flight is truncated asynchronously.
//  Invariant: leftSignal+rightSignal+upSignal+downSignal <= 1 in every cycle.
// TESTING (sim with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, GRAVITY_PERIOD=50)
//  1 Glitch: btn_left high 3 cycles then low -> no leftSignal pulse ever.
//  2 Hold left 60 cycles -> first pulse ~7 cycles after press, second 20 cycles later, then every 8; stops within 7 cycles of release.
//  3 Hold up 100 cycles -> exactly one upSignal pulse; release + re-press -> exactly one more.
//  4 gravity_en=1, no buttons, 200 cycles -> 4 downSignal pulses spaced exactly 50 cycles; gravity_en=0 -> none.
//  5 Up and left debounce in the same cycle -> upSignal at N+1, leftSignal at N+2, never together; invariant checked each cycle.
//  6 freeze=1 while left held across a repeat boundary -> no pulse; assert reset mid-hold -> outputs 0 at once, no pulse until re-press.

Source files
------------

// File: rtl/move_cmd_gen.sv
// Turns raw push-buttons plus a gravity timer into single-cycle move pulses.
// Includes sync/debounce, auto-repeat FSMs and a fixed-priority one-hot arbiter.
module move_cmd_gen #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 15000000,
   parameter int REPEAT_RATE     = 5000000,
   parameter int GRAVITY_PERIOD  = 25000000,
   parameter int CNT_W           = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_left,
   input  logic btn_right,
   input  logic btn_up,
   input  logic btn_down,
   input  logic gravity_en,
   input  logic freeze,
   output logic leftSignal,
   output logic rightSignal,
   output logic upSignal,
   output logic downSignal
);
   localparam int BL = 0;
   localparam int BR = 1;
   localparam int BU = 2;
   localparam int BD = 3;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAVITY_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HELD} btn_state_t;

   logic [3:0] raw;
   logic [3:0] sync1_reg, sync2_reg;
   logic [3:0] deb;
   logic [3:0] req;
   logic [3:0] want, grant;
   logic [3:0] pend_reg, pulse_reg;
   logic [CNT_W-1:0] grav_cnt_reg;
   logic grav_req;

   assign raw = {btn_down, btn_up, btn_right, btn_left};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic [CNT_W-1:0] deb_cnt_reg;
      logic             deb_reg;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            deb_cnt_reg <= '0;
            deb_reg     <= 1'b0;
         end else if (sync2_reg[gi] == deb_reg) begin
            deb_cnt_reg <= '0;
         end else if (deb_cnt_reg == DEB_LAST) begin
            deb_reg     <= sync2_reg[gi];
            deb_cnt_reg <= '0;
         end else begin
            deb_cnt_reg <= deb_cnt_reg + CNT_ONE;
         end
      end

      assign deb[gi] = deb_reg;

      if (gi == BU) begin : g_rot
         // Rotate fires once per press; holding never repeats.
         btn_state_t state_reg, state_next;
         logic       req_bit;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) state_reg <= IDLE;
            else       state_reg <= state_next;
         end

         always_comb begin
            state_next = state_reg;
            req_bit    = 1'b0;
            case (state_reg)
               IDLE: if (deb_reg) begin
                  req_bit    = 1'b1;
                  state_next = HELD;
               end
               HELD: if (!deb_reg) state_next = IDLE;
               default: state_next = IDLE;
            endcase
         end

         assign req[gi] = req_bit;
      end else begin : g_rep
         btn_state_t       state_reg, state_next;
         logic [CNT_W-1:0] rep_cnt_reg, rep_cnt_next;
         logic             req_bit;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               state_reg   <= IDLE;
               rep_cnt_reg <= '0;
            end else begin
               state_reg   <= state_next;
               rep_cnt_reg <= rep_cnt_next;
            end
         end

         always_comb begin
            state_next   = state_reg;
            rep_cnt_next = rep_cnt_reg;
            req_bit      = 1'b0;
            case (state_reg)
               IDLE: if (deb_reg) begin
                  req_bit      = 1'b1;
                  state_next   = DELAY;
                  rep_cnt_next = '0;
               end
               DELAY: begin
                  if (!deb_reg) begin
                     state_next = IDLE;
                  end else if (rep_cnt_reg == DLY_LAST) begin
                     req_bit      = 1'b1;
                     state_next   = REPEAT;
                     rep_cnt_next = '0;
                  end else begin
                     rep_cnt_next = rep_cnt_reg + CNT_ONE;
                  end
               end
               REPEAT: begin
                  if (!deb_reg) begin
                     state_next = IDLE;
                  end else if (rep_cnt_reg == RATE_LAST) begin
                     req_bit      = 1'b1;
                     rep_cnt_next = '0;
                  end else begin
                     rep_cnt_next = rep_cnt_reg + CNT_ONE;
                  end
               end
               default: state_next = IDLE;
            endcase
         end

         assign req[gi] = req_bit;
      end
   end

   // Gravity pauses (keeps its phase) during freeze but restarts from 0 when disabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grav_cnt_reg <= '0;
      end else if (!gravity_en) begin
         grav_cnt_reg <= '0;
      end else if (!freeze) begin
         if (grav_cnt_reg == GRAV_LAST) grav_cnt_reg <= '0;
         else                           grav_cnt_reg <= grav_cnt_reg + CNT_ONE;
      end
   end

   assign grav_req = gravity_en & ~freeze & (grav_cnt_reg == GRAV_LAST);

   always_comb begin
      want     = pend_reg | req;
      want[BD] = want[BD] | grav_req;
      grant    = '0;
      if (want[BU])      grant[BU] = 1'b1;
      else if (want[BL]) grant[BL] = 1'b1;
      else if (want[BR]) grant[BR] = 1'b1;
      else if (want[BD]) grant[BD] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_reg  <= '0;
         pulse_reg <= '0;
      end else if (freeze) begin
         pend_reg  <= '0;
         pulse_reg <= '0;
      end else begin
         pend_reg  <= want & ~grant;
         pulse_reg <= grant;
      end
   end

   assign leftSignal  = pulse_reg[BL];
   assign rightSignal = pulse_reg[BR];
   assign upSignal    = pulse_reg[BU];
   assign downSignal  = pulse_reg[BD];
endmodule
